// File: rtl/knn_vote_pkg.sv
// Shared types and constants for the k-NN vote block: FSM states, class-width
// derivation and the width of the per-class vote counters.
package knn_vote_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    function automatic int class_w(input int nbr_class);
        return (nbr_class > 1) ? $clog2(nbr_class) : 1;
    endfunction

endpackage

// File: rtl/knn_vote_if.sv
// Bundle of the label-write port, the neighbour stream, the result stream and
// the error flag; master drives stimulus, slave is the vote block.
interface knn_vote_if
    import knn_vote_pkg::*;
#(
    parameter int ID_W    = 8,
    parameter int CLASS_W = 2
);
    logic               lbl_we;
    logic [ID_W-1:0]    lbl_addr;
    logic [CLASS_W-1:0] lbl_data;
    logic               nb_valid;
    logic               nb_ready;
    logic [ID_W-1:0]    nb_id;
    logic               nb_last;
    logic               cls_valid;
    logic               cls_ready;
    logic [CLASS_W-1:0] cls_label;
    logic [CNT_W-1:0]   cls_votes;
    logic               err;

    modport master (
        output lbl_we, lbl_addr, lbl_data, nb_valid, nb_id, nb_last, cls_ready,
        input  nb_ready, cls_valid, cls_label, cls_votes, err
    );

    modport slave (
        input  lbl_we, lbl_addr, lbl_data, nb_valid, nb_id, nb_last, cls_ready,
        output nb_ready, cls_valid, cls_label, cls_votes, err
    );

endinterface

// File: rtl/knn_vote_argmax.sv
// Combinational argmax over the class counters; equal counts go to the class
// whose first vote came from the nearest neighbour (lowest rank).
module knn_vote_argmax
    import knn_vote_pkg::*;
#(
    parameter int NBR_CLASS = 4,
    parameter int CLASS_W   = 2,
    parameter int RANK_W    = 3
) (
    input  logic [NBR_CLASS-1:0][CNT_W-1:0]  cnt_i,
    input  logic [NBR_CLASS-1:0][RANK_W-1:0] rank_i,
    output logic [CLASS_W-1:0]               label_o,
    output logic [CNT_W-1:0]                 votes_o
);

    logic [RANK_W-1:0] best_rank;

    always_comb begin
        label_o   = '0;
        votes_o   = cnt_i[0];
        best_rank = rank_i[0];
        for (int c = 1; c < NBR_CLASS; c++) begin
            if ((cnt_i[c] > votes_o) ||
                ((cnt_i[c] == votes_o) && (rank_i[c] < best_rank))) begin
                label_o   = CLASS_W'(c);
                votes_o   = cnt_i[c];
                best_rank = rank_i[c];
            end
        end
    end

endmodule

// File: rtl/knn_vote.sv
// k-NN majority vote: labels each incoming neighbour ID, accumulates per-class
// votes and emits the winning class. Define KNN_VOTE_WEIGHT_EN for rank weights.
module knn_vote
    import knn_vote_pkg::*;
#(
    parameter int NBR_KNN   = 4,
    parameter int NBR_DATAP = 10,
    parameter int NBR_CLASS = 4,
    parameter int ID_W      = 8
) (
    input logic       clk,
    input logic       rst,
    knn_vote_if.slave bus
);

    localparam int CLASS_W = class_w(NBR_CLASS);
    localparam int RANK_W  = $clog2(NBR_KNN + 1);
    localparam logic [RANK_W-1:0] RANK_NONE = RANK_W'(NBR_KNN);
    localparam logic [ID_W:0]     DATAP_LIM = (ID_W + 1)'(NBR_DATAP);

    state_t                           state_q;
    logic [CLASS_W-1:0]               lbl_q [NBR_DATAP];
    logic [NBR_CLASS-1:0][CNT_W-1:0]  cnt_q;
    logic [NBR_CLASS-1:0][RANK_W-1:0] frank_q;
    logic [RANK_W-1:0]                rank_q;
    logic                             err_q;
    logic [CLASS_W-1:0]               label_q;
    logic [CNT_W-1:0]                 votes_q;

    logic               xfer, id_ok, rank_ok, vote;
    logic [CLASS_W-1:0] vote_lbl;
    logic [CNT_W-1:0]   weight;
    logic [CLASS_W-1:0] win_label;
    logic [CNT_W-1:0]   win_votes;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                  input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign bus.nb_ready  = (state_q == IDLE) || (state_q == COLLECT);
    assign bus.cls_valid = (state_q == OUTPUT);
    assign bus.cls_label = label_q;
    assign bus.cls_votes = votes_q;
    assign bus.err       = err_q;

    assign xfer    = bus.nb_valid && bus.nb_ready;
    assign id_ok   = {1'b0, bus.nb_id} < DATAP_LIM;
    assign rank_ok = rank_q < RANK_NONE;
    assign vote    = xfer && id_ok && rank_ok;

`ifdef KNN_VOTE_WEIGHT_EN
    assign weight = CNT_W'(NBR_KNN) - CNT_W'(rank_q);
`else
    assign weight = CNT_W'(1);
`endif

    // Lookup reads the registered table, so a same-cycle write is not yet visible
    always_comb begin
        vote_lbl = '0;
        for (int i = 0; i < NBR_DATAP; i++) begin
            if (bus.nb_id == ID_W'(i)) vote_lbl = lbl_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NBR_DATAP; i++) lbl_q[i] <= '0;
        end else if (bus.lbl_we) begin
            for (int i = 0; i < NBR_DATAP; i++) begin
                if (bus.lbl_addr == ID_W'(i)) lbl_q[i] <= bus.lbl_data;
            end
        end
    end

    knn_vote_argmax #(
        .NBR_CLASS (NBR_CLASS),
        .CLASS_W   (CLASS_W),
        .RANK_W    (RANK_W)
    ) u_argmax (
        .cnt_i   (cnt_q),
        .rank_i  (frank_q),
        .label_o (win_label),
        .votes_o (win_votes)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frank_q <= {NBR_CLASS{RANK_NONE}};
            rank_q  <= '0;
            err_q   <= 1'b0;
            label_q <= '0;
            votes_q <= '0;
        end else begin
            if (xfer) begin
                if (!id_ok || !rank_ok) err_q <= 1'b1;
                for (int c = 0; c < NBR_CLASS; c++) begin
                    if (vote && (vote_lbl == CLASS_W'(c))) begin
                        cnt_q[c] <= sat_add(cnt_q[c], weight);
                        if (rank_q < frank_q[c]) frank_q[c] <= rank_q;
                    end
                end
                // Rank saturates at NBR_KNN so every later entry stays out of range
                if (bus.nb_last)  rank_q <= '0;
                else if (rank_ok) rank_q <= rank_q + 1'b1;
            end
            case (state_q)
                IDLE:    if (xfer) state_q <= bus.nb_last ? DECIDE : COLLECT;
                COLLECT: if (xfer && bus.nb_last) state_q <= DECIDE;
                DECIDE: begin
                    label_q <= win_label;
                    votes_q <= win_votes;
                    state_q <= OUTPUT;
                end
                OUTPUT: begin
                    if (bus.cls_ready) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        frank_q <= {NBR_CLASS{RANK_NONE}};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote: expected results are queued as each test point
// is driven and compared when the block hands over a result.
module tb_knn_vote;
    import knn_vote_pkg::*;

    localparam int NBR_KNN   = 4;
    localparam int NBR_DATAP = 10;
    localparam int NBR_CLASS = 4;
    localparam int ID_W      = 8;
    localparam int CLASS_W   = 2;

    typedef struct {
        int label;
        int votes;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    knn_vote_if #(.ID_W(ID_W), .CLASS_W(CLASS_W)) bus();

    knn_vote #(
        .NBR_KNN   (NBR_KNN),
        .NBR_DATAP (NBR_DATAP),
        .NBR_CLASS (NBR_CLASS),
        .ID_W      (ID_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    int   lbl_m [NBR_DATAP];
    int   pt_ids[$];
    res_t sb_q[$];
    bit   err_m;
    int   wr_idx = -1;
    int   wr_addr, wr_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: the winner holds the largest total; among equal totals it is
    // the class of the nearest neighbour that voted.
    function automatic res_t model();
        int   cnt[NBR_CLASS];
        int   best;
        int   w;
        res_t r;
        for (int c = 0; c < NBR_CLASS; c++) cnt[c] = 0;
        for (int k = 0; k < pt_ids.size(); k++) begin
            if (pt_ids[k] < NBR_DATAP && k < NBR_KNN) begin
`ifdef KNN_VOTE_WEIGHT_EN
                w = NBR_KNN - k;
`else
                w = 1;
`endif
                cnt[lbl_m[pt_ids[k]]] = (cnt[lbl_m[pt_ids[k]]] + w > 255) ? 255 : cnt[lbl_m[pt_ids[k]]] + w;
            end
        end
        best = 0;
        for (int c = 0; c < NBR_CLASS; c++) if (cnt[c] > best) best = c >= 0 ? cnt[c] : best;
        r.votes = best;
        r.label = 0;
        if (best > 0) begin
            for (int k = NBR_KNN - 1; k >= 0; k--) begin
                if (k < pt_ids.size() && pt_ids[k] < NBR_DATAP && cnt[lbl_m[pt_ids[k]]] == best)
                    r.label = lbl_m[pt_ids[k]];
            end
        end
        return r;
    endfunction

    task automatic wr_lbl(input int addr, input int data);
        bus.lbl_we   = 1'b1;
        bus.lbl_addr = ID_W'(addr);
        bus.lbl_data = CLASS_W'(data);
        @(posedge clk); #1;
        bus.lbl_we = 1'b0;
        if (addr < NBR_DATAP) lbl_m[addr] = data;
    endtask

    task automatic send_ids(input bit with_last);
        int k;
        for (int i = 0; i < pt_ids.size(); i++) begin
            k = 0;
            while (!bus.nb_ready && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            if (!bus.nb_ready) chk("nb_ready_timeout", 0, 1);
            bus.nb_valid = 1'b1;
            bus.nb_id    = ID_W'(pt_ids[i]);
            bus.nb_last  = with_last && (i == pt_ids.size() - 1);
            if (i == wr_idx) begin
                bus.lbl_we   = 1'b1;
                bus.lbl_addr = ID_W'(wr_addr);
                bus.lbl_data = CLASS_W'(wr_data);
            end
            @(posedge clk); #1;
            bus.nb_valid = 1'b0;
            bus.nb_last  = 1'b0;
            if (i == wr_idx) begin
                bus.lbl_we = 1'b0;
                if (wr_addr < NBR_DATAP) lbl_m[wr_addr] = wr_data;
            end
        end
        wr_idx = -1;
    endtask

    task automatic run_pt(input bit wait_done);
        sb_q.push_back(model());
        for (int k = 0; k < pt_ids.size(); k++)
            if (pt_ids[k] >= NBR_DATAP || k >= NBR_KNN) err_m = 1'b1;
        send_ids(1'b1);
        chk("lat_decide_valid", 32'(bus.cls_valid), 0);
        chk("lat_decide_ready", 32'(bus.nb_ready), 0);
        @(posedge clk); #1;
        chk("lat_output_valid", 32'(bus.cls_valid), 1);
        if (wait_done) begin
            for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
            if (sb_q.size() != 0) chk("result_timeout", 32'(sb_q.size()), 0);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst && bus.cls_valid && bus.cls_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                chk("cls_label", 32'(bus.cls_label), 32'(sb_q[0].label));
                chk("cls_votes", 32'(bus.cls_votes), 32'(sb_q[0].votes));
                void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        bus.lbl_we = 1'b0; bus.lbl_addr = '0; bus.lbl_data = '0;
        bus.nb_valid = 1'b0; bus.nb_id = '0; bus.nb_last = 1'b0;
        bus.cls_ready = 1'b1;
        for (int i = 0; i < NBR_DATAP; i++) lbl_m[i] = 0;
        err_m = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cls_valid", 32'(bus.cls_valid), 0);
        chk("rst_cls_label", 32'(bus.cls_label), 0);
        chk("rst_cls_votes", 32'(bus.cls_votes), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_nb_ready", 32'(bus.nb_ready), 1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Plain majority
        wr_lbl(0, 1); wr_lbl(1, 1); wr_lbl(2, 2); wr_lbl(3, 3);
        pt_ids = '{2, 0, 1, 3};
        run_pt(1'b1);

        // Tie resolved by nearest neighbour
        wr_lbl(0, 2); wr_lbl(1, 3); wr_lbl(2, 2); wr_lbl(3, 3);
        pt_ids = '{1, 0, 3, 2};
        run_pt(1'b1);
        chk("err_clean", 32'(bus.err), 32'(err_m));

        // Short point, weight-sensitive outcome
        wr_lbl(0, 0); wr_lbl(1, 1); wr_lbl(2, 1);
        pt_ids = '{0, 1, 2};
        run_pt(1'b1);

        // Label write to an ID during its own lookup must see the old label
        wr_lbl(0, 1); wr_lbl(1, 2); wr_lbl(3, 0);
        pt_ids = '{0, 1, 3};
        wr_idx = 0; wr_addr = 0; wr_data = 3;
        run_pt(1'b1);
        wr_lbl(12, 3);

        // Consumer stalls: result held, no new neighbours accepted
        bus.cls_ready = 1'b0;
        pt_ids = '{0, 2};
        run_pt(1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.cls_valid), 1);
            chk("hold_label", 32'(bus.cls_label), 32'(sb_q[0].label));
            chk("hold_votes", 32'(bus.cls_votes), 32'(sb_q[0].votes));
            chk("hold_nb_ready", 32'(bus.nb_ready), 0);
        end
        bus.cls_ready = 1'b1;
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
        if (sb_q.size() != 0) chk("stall_release_timeout", 32'(sb_q.size()), 0);
        #1;

        // Out-of-range ID
        pt_ids = '{0, 12, 1};
        run_pt(1'b1);
        chk("err_bad_id", 32'(bus.err), 1);

        // Reset in the middle of a test point
        wr_lbl(3, 3);
        pt_ids = '{3, 3};
        send_ids(1'b0);
        rst = 1'b0;
        #2;
        chk("midrst_cls_valid", 32'(bus.cls_valid), 0);
        chk("midrst_err", 32'(bus.err), 0);
        chk("midrst_nb_ready", 32'(bus.nb_ready), 1);
        for (int i = 0; i < NBR_DATAP; i++) lbl_m[i] = 0;
        err_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_label", 32'(bus.cls_label), 0);
        wr_lbl(0, 1); wr_lbl(1, 2); wr_lbl(2, 2);
        pt_ids = '{0, 1, 3, 2, 1};
        run_pt(1'b1);
        chk("err_rank_overflow", 32'(bus.err), 32'(err_m));

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
